load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the max cycles spent in WAIT before an error response; legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low; low SHALL force reset state immediately regardless of clk.
REQ-004 req_valid  in  1  request present; req_ready  out  1  unit can accept.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_op  in  3  load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store uses [1:0]: 00 sb, 01 sh, 10 sw; [2] ignored for stores.
REQ-007 req_addr  in  32  byte address (ALU result); req_wdata  in  32  store data (rs2).
REQ-008 resp_valid  out  1; resp_ready  in  1; resp_rdata  out  32  formatted load data; resp_err  out  1  misaligned/illegal/timeout.
REQ-009 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  32 word-aligned; mem_we  out  1; mem_wmask  out  4; mem_wdata  out  32.
REQ-010 mem_rvalid  in  1  completion (load data or store ack); mem_rdata  in  32.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, RESP; only IDLE asserts req_ready.
REQ-012 Handshake on req_valid&req_ready SHALL latch we, op, addr, wdata; outputs SHALL depend only on latched values thereafter.
REQ-013 Accepted request illegal (load op 011/110/111, store op[1:0]=11) or misaligned (halfword addr[0]=1; word addr[1:0]!=0) SHALL go IDLE->RESP, resp_err=1, resp_rdata=0, no memory access.
REQ-014 Otherwise IDLE->REQ; REQ SHALL hold mem_req_valid=1 with stable mem_addr/mem_we/mem_wmask/mem_wdata until mem_req_ready, then ->WAIT.
REQ-015 mem_addr SHALL be {addr[31:2],2'b00}; mem_we = latched we; loads SHALL drive mem_wmask=0000.
REQ-016 Store lanes: sb wdata={4{wdata[7:0]}}, wmask=0001<<addr[1:0]; sh wdata={2{wdata[15:0]}}, wmask=0011<<addr[1:0]; sw wdata, wmask=1111.
REQ-017 WAIT SHALL clear a cycle counter on entry, increment each cycle without mem_rvalid; mem_rvalid SHALL be sampled only in WAIT.
REQ-018 mem_rvalid in WAIT SHALL ->RESP, resp_err=0, resp_rdata = formatted load data (stores: 0).
REQ-019 Counter reaching TIMEOUT without mem_rvalid SHALL ->RESP, resp_err=1, resp_rdata=0; mem_rvalid and timeout in same cycle: data wins.
REQ-020 Load format: byte = mem_rdata lane addr[1:0], halfword = lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes word.
REQ-021 RESP SHALL hold resp_valid=1 and stable resp_rdata/resp_err until resp_ready, then ->IDLE; no new request accepted before that edge.
REQ-022 Minimum latency: accept cycle 0, mem_req_valid cycle 1, with mem_req_ready cycle 1 and mem_rvalid cycle 2 -> resp_valid cycle 3.
REQ-023 mem_rvalid outside WAIT SHALL be ignored; one outstanding memory transaction maximum.

Reset
REQ-024 While rst=0: state IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, mem_req_valid=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-transaction SHALL discard it; any later mem_rvalid SHALL be ignored (state IDLE).

Verification
REQ-026 lb addr=0x8000_0003, mem_rdata=0x80FF_1234, zero-wait memory -> mem_addr 0x8000_0000, resp_rdata 0xFFFF_FF80, err 0, resp_valid cycle 3.
REQ-027 sh addr=0x100 2, wdata=0x0000_ABCD -> mem_wdata 0xABCD_ABCD, mem_wmask 1100, mem_we 1; ack -> resp_rdata 0, err 0.
REQ-028 lw addr=0x1001 -> no mem_req_valid ever, resp_valid cycle 1, resp_err 1, rdata 0.
REQ-029 TIMEOUT=4, load, mem_rvalid never -> resp_err 1 after 4 WAIT cycles; mem_req_ready held low 3 cycles -> mem_req_valid and fields stable 4 cycles.
REQ-030 resp_ready low 5 cycles, new req_valid pending -> req_ready 0 throughout, resp fields stable; rst pulse low in WAIT -> IDLE, late mem_rvalid produces no response.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: formats byte/half/word accesses onto a word-wide memory port.
// Requests are latched on accept; illegal or misaligned requests respond with an
// error without touching memory. A WAIT-state counter bounds the memory latency.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        bad_req;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;

  // Classify the incoming request: unknown opcode or misaligned address
  always_comb begin
    bad_req = 1'b0;
    if (req_we) bad_req = (req_op[1:0] == 2'b11);
    else        bad_req = (req_op == 3'b011) || (req_op[2:1] == 2'b11);
    if (req_op[1:0] == 2'b01 && req_addr[0])          bad_req = 1'b1;
    if (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00) bad_req = 1'b1;
  end

  // Extract and extend the addressed lane of the returned word
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data  = '0;
    if (!we_q) begin
      case (op_q)
        3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
        3'b010:  ld_data = mem_rdata;
        3'b100:  ld_data = {24'b0, byte_sel};
        3'b101:  ld_data = {16'b0, half_sel};
        default: ld_data = '0;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state; request fields latch on accept, response fields on entry to RESP
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (bad_req) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = REQ;
        end
      end
      REQ: if (mem_req_ready) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A completion arriving on the last allowed cycle still counts as data
        if (mem_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = ld_data;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs derive only from state and latched request fields
  always_comb begin
    req_ready     = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    resp_valid    = (state_q == RESP);
    resp_rdata    = rdata_q;
    resp_err      = err_q;
    mem_addr      = {addr_q[31:2], 2'b00};
    mem_we        = we_q;
    mem_wmask     = 4'b0000;
    mem_wdata     = '0;
    if (we_q) begin
      case (op_q[1:0])
        2'b00: begin
          mem_wmask = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_wmask = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{wdata_q[15:0]}};
        end
        2'b10: begin
          mem_wmask = 4'b1111;
          mem_wdata = wdata_q;
        end
        default: begin
          mem_wmask = 4'b0000;
          mem_wdata = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized transaction-level check of load_store_unit against a byte-lane model.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_vec = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: access size from op, legality, byte-lane store image, extended load value
  task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] md,
                       output bit bad, output logic [3:0] msk,
                       output logic [31:0] wexp, output logic [31:0] rexp);
    int sz, off;
    logic [31:0] v, lm;
    sz  = 1 << (op % 4);
    off = addr % 4;
    bad = we ? (op % 4 == 3) : !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (addr % sz != 0) bad = 1;
    msk = 4'b0; wexp = 32'b0; rexp = 32'b0;
    if (!bad) begin
      if (we) begin
        msk = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      wexp = {24'b0, wd[7:0]} * 32'h0101_0101;
        else if (sz == 2) wexp = {16'b0, wd[15:0]} * 32'h0001_0001;
        else              wexp = wd;
      end else begin
        lm = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v  = (md >> (8 * off)) & lm;
        if (op < 4 && sz < 4 && v[8 * sz - 1]) v = v | ~lm;
        rexp = v;
      end
    end
  endtask

  // One full transaction; enters and leaves just after a falling edge
  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] md,
                         input int req_stall, input int lat, input int resp_stall);
    bit bad, got_data;
    logic [3:0] em;
    logic [31:0] ew, erd, x_rd;
    logic x_err;
    model(we, op, addr, wd, md, bad, em, ew, erd);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_we = $urandom % 2; req_op = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    got_data = 0;
    if (bad) begin
      chk("bad_no_mreq", mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= req_stall; i++) begin
        chk("mreq_valid", mem_req_valid, 1);
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_we", mem_we, we);
        chk("mem_wmask", mem_wmask, em);
        if (we) chk("mem_wdata", mem_wdata, ew);
        chk("req_busy", req_ready, 0);
        chk("resp_early", resp_valid, 0);
        mem_req_ready = (i == req_stall);
        mem_rvalid = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
      end
      mem_req_ready = 0;
      for (int i = 0; i < TMO; i++) begin
        chk("wait_no_mreq", mem_req_valid, 0);
        chk("wait_no_resp", resp_valid, 0);
        mem_rvalid = (i == lat);
        mem_rdata = (i == lat) ? md : $urandom;
        @(negedge clk);
        if (i == lat) begin
          got_data = 1;
          break;
        end
      end
      mem_rvalid = 0;
    end
    x_err = !got_data;
    x_rd  = got_data ? erd : 32'b0;
    chk("resp_valid", resp_valid, 1);
    chk("resp_err", resp_err, x_err);
    chk("resp_rdata", resp_rdata, x_rd);
    for (int i = 0; i < resp_stall; i++) begin
      resp_ready = 0;
      req_valid = 1'($urandom); req_addr = $urandom; req_op = 3'($urandom);
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_err", resp_err, x_err);
      chk("stall_resp_rdata", resp_rdata, x_rd);
      chk("stall_no_mreq", mem_req_valid, 0);
    end
    req_valid = 0; mem_rvalid = 0; resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("resp_done", resp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask

  initial begin
    rst = 0; req_valid = 0; req_we = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mreq_valid", mem_req_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1;
    chk("rst_req_ready", req_ready, 1);

    // Signed byte load from top lane, zero-wait memory
    run_txn(0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    // Halfword store to upper half
    run_txn(1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0, 0, 0);
    // Misaligned word load
    run_txn(0, 3'b010, 32'h0000_1001, 32'h0, 32'h0, 0, 0, 0);
    // Slow request acceptance then no completion: timeout
    run_txn(0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 3, 100, 0);
    // Completion on the final allowed WAIT cycle
    run_txn(0, 3'b101, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 0, TMO - 1, 0);
    // Long response backpressure with new requests pending
    run_txn(0, 3'b100, 32'h0000_0011, 32'h0, 32'hDEAD_BEEF, 1, 2, 5);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 3 == 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), 3'($urandom), a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // Reset in WAIT discards the transaction; later completions are ignored
    req_valid = 1; req_we = 0; req_op = 3'b010; req_addr = 32'h200;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_mreq_valid", mem_req_valid, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rvalid_resp", resp_valid, 0);
      chk("late_rvalid_idle", req_ready, 1);
    end
    mem_rvalid = 0;
    run_txn(0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
